vsm_stream: RTL and testbench

Parametrised, streaming successor to the vector-scalar multiply-accumulate unit. It accepts a stream of (vector, scalar) beats over a valid/ready handshake and accumulates `SIZE` lane products per beat. On a beat flagged `in_last`, it emits the finished accumulator vector on a held output register with its own valid/ready handshake. It sits between the weight/activation fetch logic and the activation stage of the neural-network datapath. It adds configurable widths, signed mode, saturation, overflow reporting, abort and backpressure.

---
 rtl/vsm_stream.sv | 104 ++++++++++
 tb/tb_vsm_stream.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vsm_stream.sv
// Streaming vector-scalar multiply-accumulate: SIZE lane products per beat are accumulated,
// and the result is emitted on a held, handshaked output register when in_last is accepted.
module vsm_stream #(
   parameter int SIZE   = 4,
   parameter int IN_W   = 8,
   parameter int ACC_W  = 20,
   parameter int SIGNED = 0,
   parameter int SAT    = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_last,
   input  logic [SIZE*IN_W-1:0]  a,
   input  logic [IN_W-1:0]       b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [SIZE*ACC_W-1:0] out,
   output logic                  out_ovf
);

   logic [SIZE-1:0][ACC_W-1:0] r_acc;
   logic [SIZE-1:0][ACC_W-1:0] r_out;
   logic                       r_out_valid;
   logic                       r_out_ovf;
   logic                       r_sticky;

   logic [SIZE-1:0][ACC_W-1:0] w_sum;
   logic [SIZE-1:0]            w_lane_ovf;
   logic [2*IN_W-1:0]          w_ax   [SIZE];
   logic [2*IN_W-1:0]          w_bx   [SIZE];
   logic [2*IN_W-1:0]          w_prod [SIZE];
   logic [ACC_W+2*IN_W-1:0]    w_pwide[SIZE];
   logic [ACC_W:0]             w_s    [SIZE];
   logic                       w_fire;
   logic                       w_any_ovf;

   // Packed index j matches the bit position of lane (SIZE-1-j) in both a and out.
   always_comb begin
      for (int j = 0; j < SIZE; j++) begin
         w_ax[j]    = {{IN_W{(SIGNED != 0) & a[j*IN_W+IN_W-1]}}, a[j*IN_W +: IN_W]};
         w_bx[j]    = {{IN_W{(SIGNED != 0) & b[IN_W-1]}}, b};
         w_prod[j]  = w_ax[j] * w_bx[j];
         w_pwide[j] = {{ACC_W{(SIGNED != 0) & w_prod[j][2*IN_W-1]}}, w_prod[j]};
         w_s[j]     = {(SIGNED != 0) & r_acc[j][ACC_W-1], r_acc[j]}
                    + {(SIGNED != 0) & w_pwide[j][ACC_W-1], w_pwide[j][ACC_W-1:0]};
         if (SIGNED != 0) begin
            w_lane_ovf[j] = w_s[j][ACC_W] ^ w_s[j][ACC_W-1];
         end else begin
            w_lane_ovf[j] = w_s[j][ACC_W];
         end
         w_sum[j] = w_s[j][ACC_W-1:0];
         if ((SAT != 0) && w_lane_ovf[j]) begin
            if (SIGNED != 0) begin
               // Bit ACC_W carries the true sign of the out-of-range result.
               w_sum[j] = {w_s[j][ACC_W], {(ACC_W-1){~w_s[j][ACC_W]}}};
            end else begin
               w_sum[j] = {ACC_W{1'b1}};
            end
         end
      end
   end

   assign w_any_ovf = |w_lane_ovf;
   assign in_ready  = reset & ~clear & (~r_out_valid | out_ready);
   assign w_fire    = in_valid & in_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_acc       <= '0;
         r_out       <= '0;
         r_out_valid <= 1'b0;
         r_out_ovf   <= 1'b0;
         r_sticky    <= 1'b0;
      end else begin
         if (clear) begin
            r_acc    <= '0;
            r_sticky <= 1'b0;
         end else if (w_fire) begin
            if (in_last) begin
               r_acc     <= '0;
               r_sticky  <= 1'b0;
               r_out     <= w_sum;
               r_out_ovf <= r_sticky | w_any_ovf;
            end else begin
               r_acc    <= w_sum;
               r_sticky <= r_sticky | w_any_ovf;
            end
         end
         if (w_fire && in_last) begin
            r_out_valid <= 1'b1;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out       = r_out;
   assign out_valid = r_out_valid;
   assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_vsm_stream.sv
// Directed bench for vsm_stream: four instances share one stimulus stream and differ in
// signedness, accumulator width and saturation mode.
module tb_vsm_stream;

   logic        clk;
   logic        reset;
   logic        clear;
   logic        in_valid;
   logic        in_last;
   logic        out_ready;
   logic [23:0] a;
   logic [7:0]  b;

   logic        rdy_u, rdy_s, rdy_c, rdy_w;
   logic        val_u, val_s, val_c, val_w;
   logic        ovf_u, ovf_s, ovf_c, ovf_w;
   logic [59:0] out_u, out_s;
   logic [47:0] out_c, out_w;

   int errors = 0;
   int checks = 0;

   vsm_stream #(.SIZE(3), .IN_W(8), .ACC_W(20), .SIGNED(0), .SAT(0)) dut_u (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(rdy_u),
      .in_last(in_last), .a(a), .b(b), .out_valid(val_u), .out_ready(out_ready),
      .out(out_u), .out_ovf(ovf_u));

   vsm_stream #(.SIZE(3), .IN_W(8), .ACC_W(20), .SIGNED(1), .SAT(1)) dut_s (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(rdy_s),
      .in_last(in_last), .a(a), .b(b), .out_valid(val_s), .out_ready(out_ready),
      .out(out_s), .out_ovf(ovf_s));

   vsm_stream #(.SIZE(3), .IN_W(8), .ACC_W(16), .SIGNED(0), .SAT(1)) dut_c (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(rdy_c),
      .in_last(in_last), .a(a), .b(b), .out_valid(val_c), .out_ready(out_ready),
      .out(out_c), .out_ovf(ovf_c));

   vsm_stream #(.SIZE(3), .IN_W(8), .ACC_W(16), .SIGNED(0), .SAT(0)) dut_w (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(rdy_w),
      .in_last(in_last), .a(a), .b(b), .out_valid(val_w), .out_ready(out_ready),
      .out(out_w), .out_ovf(ovf_w));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [23:0] av, input logic [7:0] bv, input logic v,
                        input logic l);
      a        = av;
      b        = bv;
      in_valid = v;
      in_last  = l;
   endtask

   task automatic test_reset;
      #3;
      checks++;
      if (out_u !== 60'h0 || val_u !== 1'b0 || ovf_u !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got out=%h valid=%b ovf=%b need 0", out_u, val_u, ovf_u);
      end
      checks++;
      if (rdy_u !== 1'b0) begin
         errors++;
         $display("FAIL reset_in_ready: got %b need 0", rdy_u);
      end
      tick();
      reset = 1'b1;
      #1;
      checks++;
      if (rdy_u !== 1'b1 || rdy_c !== 1'b1) begin
         errors++;
         $display("FAIL release_in_ready: got %b/%b need 1", rdy_u, rdy_c);
      end
      tick();
   endtask

   task automatic test_accumulate;
      out_ready = 1'b1;
      drive(24'h010407, 8'h01, 1'b1, 1'b0);
      tick();
      checks++;
      if (val_u !== 1'b0) begin
         errors++;
         $display("FAIL acc_early_valid: got %b need 0", val_u);
      end
      drive(24'h020508, 8'h02, 1'b1, 1'b0);
      tick();
      drive(24'h030609, 8'h03, 1'b1, 1'b1);
      tick();
      drive(24'h0, 8'h0, 1'b0, 1'b0);
      checks++;
      if (out_u !== {20'h0000E, 20'h00020, 20'h00032} || ovf_u !== 1'b0 || val_u !== 1'b1) begin
         errors++;
         $display("FAIL acc_result: got out=%h ovf=%b valid=%b need 0000e00020 00032 0 1",
                  out_u, ovf_u, val_u);
      end
      tick();
      checks++;
      if (val_u !== 1'b0) begin
         errors++;
         $display("FAIL acc_valid_one_cycle: got %b need 0", val_u);
      end
   endtask

   task automatic test_signed;
      drive(24'hFF0280, 8'hFF, 1'b1, 1'b1);
      tick();
      checks++;
      if (out_s !== {20'h00001, 20'hFFFFE, 20'h00080} || ovf_s !== 1'b0) begin
         errors++;
         $display("FAIL signed_single: got %h ovf=%b need 00001fffffe00080 0", out_s, ovf_s);
      end
      checks++;
      if (out_u !== {20'h0FE01, 20'h001FE, 20'h07F80}) begin
         errors++;
         $display("FAIL unsigned_same_beat: got %h need 0fe01001fe07f80", out_u);
      end
      drive(24'h010101, 8'h01, 1'b1, 1'b1);
      tick();
      checks++;
      if (out_s !== {20'h00001, 20'h00001, 20'h00001}) begin
         errors++;
         $display("FAIL signed_cleared: got %h need 000010000100001", out_s);
      end
      drive(24'h0, 8'h0, 1'b0, 1'b0);
      tick();
   endtask

   task automatic test_saturation;
      drive(24'hFF0000, 8'hFF, 1'b1, 1'b0);
      tick();
      drive(24'hFF0000, 8'hFF, 1'b1, 1'b1);
      tick();
      checks++;
      if (out_c !== {16'hFFFF, 16'h0, 16'h0} || ovf_c !== 1'b1) begin
         errors++;
         $display("FAIL sat_clamp: got %h ovf=%b need ffff00000000 1", out_c, ovf_c);
      end
      checks++;
      if (out_w !== {16'hFC02, 16'h0, 16'h0} || ovf_w !== 1'b1) begin
         errors++;
         $display("FAIL sat_wrap: got %h ovf=%b need fc0200000000 1", out_w, ovf_w);
      end
      checks++;
      if (out_u !== {20'h1FC02, 20'h0, 20'h0} || ovf_u !== 1'b0) begin
         errors++;
         $display("FAIL sat_wide_no_ovf: got %h ovf=%b need 1fc02 0", out_u, ovf_u);
      end
      drive(24'h010101, 8'h01, 1'b1, 1'b1);
      tick();
      checks++;
      if (out_c !== {16'h1, 16'h1, 16'h1} || ovf_c !== 1'b0) begin
         errors++;
         $display("FAIL sat_sticky_cleared: got %h ovf=%b need 000100010001 0", out_c, ovf_c);
      end
      drive(24'h0, 8'h0, 1'b0, 1'b0);
      tick();
   endtask

   task automatic test_backpressure;
      out_ready = 1'b0;
      drive(24'h010203, 8'h01, 1'b1, 1'b1);
      tick();
      drive(24'h040404, 8'h01, 1'b1, 1'b1);
      #1;
      checks++;
      if (rdy_u !== 1'b0) begin
         errors++;
         $display("FAIL bp_in_ready: got %b need 0", rdy_u);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (out_u !== {20'h1, 20'h2, 20'h3} || val_u !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: got %h valid=%b need 000010000200003 1", out_u, val_u);
         end
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (rdy_u !== 1'b1) begin
         errors++;
         $display("FAIL bp_ready_comb: got %b need 1", rdy_u);
      end
      tick();
      drive(24'h0, 8'h0, 1'b0, 1'b0);
      checks++;
      if (out_u !== {20'h4, 20'h4, 20'h4} || val_u !== 1'b1) begin
         errors++;
         $display("FAIL bp_replace: got %h valid=%b need 000040000400004 1", out_u, val_u);
      end
      tick();
      checks++;
      if (val_u !== 1'b0) begin
         errors++;
         $display("FAIL bp_drain: got %b need 0", val_u);
      end
   endtask

   task automatic test_back_to_back;
      drive(24'h010101, 8'h01, 1'b1, 1'b1);
      tick();
      checks++;
      if (out_u !== {20'h1, 20'h1, 20'h1} || val_u !== 1'b1) begin
         errors++;
         $display("FAIL b2b_first: got %h valid=%b need 000010000100001 1", out_u, val_u);
      end
      drive(24'h020202, 8'h01, 1'b1, 1'b1);
      tick();
      checks++;
      if (out_u !== {20'h2, 20'h2, 20'h2} || val_u !== 1'b1) begin
         errors++;
         $display("FAIL b2b_second: got %h valid=%b need 000020000200002 1", out_u, val_u);
      end
      drive(24'h0, 8'h0, 1'b0, 1'b0);
      tick();
   endtask

   task automatic test_abort;
      drive(24'h010101, 8'h05, 1'b1, 1'b0);
      tick();
      clear = 1'b1;
      #1;
      checks++;
      if (rdy_u !== 1'b0) begin
         errors++;
         $display("FAIL abort_in_ready: got %b need 0", rdy_u);
      end
      tick();
      clear = 1'b0;
      drive(24'h010101, 8'h02, 1'b1, 1'b1);
      tick();
      drive(24'h0, 8'h0, 1'b0, 1'b0);
      checks++;
      if (out_u !== {20'h2, 20'h2, 20'h2} || val_u !== 1'b1) begin
         errors++;
         $display("FAIL abort_result: got %h valid=%b need 000020000200002 1", out_u, val_u);
      end
      out_ready = 1'b0;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      checks++;
      if (out_u !== {20'h2, 20'h2, 20'h2} || val_u !== 1'b1) begin
         errors++;
         $display("FAIL abort_keeps_held: got %h valid=%b need 000020000200002 1", out_u, val_u);
      end
      out_ready = 1'b1;
      tick();
   endtask

   task automatic test_mid_reset;
      drive(24'h050505, 8'h01, 1'b1, 1'b0);
      tick();
      drive(24'h0, 8'h0, 1'b0, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (out_u !== 60'h0 || val_u !== 1'b0 || ovf_u !== 1'b0 || rdy_u !== 1'b0) begin
         errors++;
         $display("FAIL midreset_async: got out=%h valid=%b ovf=%b rdy=%b need all 0",
                  out_u, val_u, ovf_u, rdy_u);
      end
      #2;
      reset = 1'b1;
      tick();
      drive(24'h010203, 8'h01, 1'b1, 1'b1);
      tick();
      drive(24'h0, 8'h0, 1'b0, 1'b0);
      checks++;
      if (out_u !== {20'h1, 20'h2, 20'h3} || val_u !== 1'b1) begin
         errors++;
         $display("FAIL midreset_after: got %h valid=%b need 000010000200003 1", out_u, val_u);
      end
      tick();
   endtask

   initial begin
      reset     = 1'b0;
      clear     = 1'b0;
      out_ready = 1'b1;
      drive(24'h0, 8'h0, 1'b0, 1'b0);
      test_reset();
      test_accumulate();
      test_signed();
      test_saturation();
      test_backpressure();
      test_back_to_back();
      test_abort();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
